ws2812_rx: RTL and testbench
============================

Name: ws2812_rx

Overview:
- Decodes a WS2812 single-wire serial stream, such as the DOUT of the last LED in a chain or a loopback of our own transmitter output, back into 24-bit GRB pixel words.
- Measures the high-pulse width of each bit, assembles bits MSB-first into pixels and detects the reset gap that ends a frame.
- Used for on-board chain verification and self-test of the rainbow/transmit path; sits beside the WS2812 transmitter on the same 50 MHz clock.

Parameters:
- NUM_LED, 8, max pixels per frame; pixels beyond this are dropped and flagged.
- T_MIN_HIGH, 5, min valid high width in clk cycles (100 ns); shorter is a glitch error.
- T_THRESH, 30, high width >= this decodes as 1, below as 0 (600 ns).
- T_MAX_HIGH, 60, high width > this is an error (1.2 us).
- T_RESET_CYC, 2500, low width ending a frame (50 us).

Ports:
- clk  in  1  50 MHz clock.
- rst_n  in  1  reset, asynchronous, active-low.
- din  in  1  asynchronous serial input.
- pixel_valid  out  1  one-cycle pulse: pixel_data/pixel_index valid.
- pixel_data  out  24  {G,R,B} as received, first bit = bit 23.
- pixel_index  out  IDX_W  position in frame, IDX_W = max(1,clog2(NUM_LED)).
- frame_done  out  1  one-cycle pulse on reset gap after at least one rising edge.
- pixel_count  out  IDX_W+1  pixels accepted in finished frame; valid with frame_done, held until next frame_done.
- frame_error  out  1  one-cycle pulse: timing violation or partial pixel.
- overflow  out  1  with frame_done: more than NUM_LED pixels were seen.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- din passes a 2-flop synchronizer to give din_s, plus a delayed copy din_q. Rise = din_s & ~din_q; fall = ~din_s & din_q.
- Width counter: CNT_W = clog2(T_RESET_CYC+1) bits, saturating. Cleared on every edge; counts the current level's duration.
- IDLE: ignore din until din_s has been low for T_RESET_CYC consecutive cycles, then go to ARMED. Applies after reset and after any error, including when din is high at reset release.
- ARMED: on rise, go to HIGH.
- HIGH, on fall with width w:
  - w < T_MIN_HIGH → error.
  - Otherwise shift in bit (w >= T_THRESH), bit_cnt+1, go to LOW.
  - Decode boundary: w = T_THRESH-1 → 0; w = T_THRESH → 1.
- HIGH, width exceeds T_MAX_HIGH with din_s still high → error immediately.
- Pixel completion: when bit_cnt reaches 24, the next cycle asserts pixel_valid with pixel_data and pixel_index = pix_cnt.
  - pix_cnt increments, saturating at NUM_LED.
  - If pix_cnt is already NUM_LED, no pixel_valid is issued and the overflow flag is set internally.
  - bit_cnt returns to 0.
- LOW:
  - rise → HIGH (low width is not checked).
  - Low width reaches T_RESET_CYC → frame end.
- Frame end:
  - frame_done pulses; pixel_count = pix_cnt; overflow = internal flag for that cycle.
  - If bit_cnt != 0, frame_error pulses in the same cycle and the partial pixel is discarded.
  - Clear pix_cnt, bit_cnt and flag; go to ARMED.
- Error:
  - frame_error pulses for one cycle; no frame_done.
  - Discard partial pixel, clear pix_cnt, bit_cnt and flag; go to IDLE.
- Latency: din pin fall to pixel_valid is 4 clk ±1 (sync uncertainty).
- Simultaneous events: a rise in the same cycle the low count reaches T_RESET_CYC is processed as frame end; that edge starts no bit, and the next rise starts the next frame.
- rst_n assertion mid-frame: immediate clear; no pulses are emitted for the aborted frame.

Decomposition:
- ws2812_pkg holds:
  - default timing constants (T0H=20, T1H=40, bit period 62, T_RESET_CYC=2500 at 50 MHz), shared with the transmitter;
  - GRB byte-field localparams (G = [23:16], R = [15:8], B = [7:0]);
  - an rx state enum {IDLE, ARMED, HIGH, LOW}.
- Sub-module ws2812_rx_sync holds the 2-flop synchronizer and rise/fall detect.

Test Plan:
1. Reset, 2600 low, one pixel 24'h00FF00 (0 = 20H/42L, 1 = 40H/22L), 2600 low → one pixel_valid with data 24'h00FF00, index 0; frame_done with pixel_count 1, frame_error 0, overflow 0.
2. 8 pixels 24'hFF0000, 24'h00FF00, …, 24'h123456 → indices 0..7 in order with exact data; pixel_count 8. Repeat with widths 29 and 30 → those bits decode as 0 and 1.
3. 9 pixels with NUM_LED=8 → exactly 8 pixel_valid; frame_done with pixel_count 8, overflow 1.
4. 12 bits then 2600 low → no pixel_valid; frame_done and frame_error in the same cycle, pixel_count 0.
5. Mid-stream 80-cycle high → frame_error; following pixels ignored until 2500 low, then the next frame decodes normally. Repeat with a 3-cycle glitch → same response.
6. rst_n low for 2 cycles during bit 10 with din held high at release → all outputs 0; nothing decoded until 2500 low; next frame correct.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: default 50 MHz timing, GRB field positions and
// the receiver state encoding.
package ws2812_pkg;

    localparam int T0H         = 20;
    localparam int T1H         = 40;
    localparam int T_BIT       = 62;
    localparam int T_RESET_DEF = 2500;

    localparam int PIXEL_BITS = 24;
    localparam int G_MSB = 23;
    localparam int G_LSB = 16;
    localparam int R_MSB = 15;
    localparam int R_LSB = 8;
    localparam int B_MSB = 7;
    localparam int B_LSB = 0;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_ARMED = 2'd1,
        RX_HIGH  = 2'd2,
        RX_LOW   = 2'd3
    } rx_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ws2812_rx_sync.sv
// Two-flop synchronizer for the WS2812 line plus a delayed copy for
// single-cycle rise/fall strobes.
module ws2812_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_din,
    output logic o_din_s,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_dly;

    // synchronizer chain and edge-detect delay stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_dly  <= 1'b0;
        end else begin
            r_meta <= i_din;
            r_sync <= r_meta;
            r_dly  <= r_sync;
        end
    end

    assign o_din_s = r_sync;
    assign o_rise  = r_sync & ~r_dly;
    assign o_fall  = ~r_sync & r_dly;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 receiver: measures high-pulse widths, assembles GRB pixels MSB-first
// and reports frame boundaries, pixel counts and timing errors.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int  NUM_LED     = 8,
    parameter int  T_MIN_HIGH  = 5,
    parameter int  T_THRESH    = 30,
    parameter int  T_MAX_HIGH  = 60,
    parameter int  T_RESET_CYC = T_RESET_DEF,
    localparam int IDX_W       = idx_width(NUM_LED)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_din,
    output logic             o_pixel_valid,
    output logic [23:0]      o_pixel_data,
    output logic [IDX_W-1:0] o_pixel_index,
    output logic             o_frame_done,
    output logic [IDX_W:0]   o_pixel_count,
    output logic             o_frame_error,
    output logic             o_overflow
);

    localparam int CNT_W = $clog2(T_RESET_CYC + 1);
    localparam int PC_W  = IDX_W + 1;
    localparam logic [CNT_W-1:0] C_RESET   = CNT_W'(T_RESET_CYC);
    localparam logic [CNT_W-1:0] C_MIN     = CNT_W'(T_MIN_HIGH);
    localparam logic [CNT_W-1:0] C_THRESH  = CNT_W'(T_THRESH);
    localparam logic [CNT_W-1:0] C_MAX     = CNT_W'(T_MAX_HIGH);
    localparam logic [PC_W-1:0]  C_NUM_LED = PC_W'(NUM_LED);
    localparam logic [4:0]       C_PIX_BITS = 5'd24;

    logic w_din_s, w_rise, w_fall;

    rx_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_width;
    logic [4:0]       r_bit_cnt, w_bit_cnt_nxt;
    logic [23:0]      r_shift, w_shift_nxt;
    logic [PC_W-1:0]  r_pix_cnt, w_pix_cnt_nxt;
    logic             r_ovf_flag, w_ovf_flag_nxt;

    logic             r_pixel_valid, w_pixel_valid_nxt;
    logic [23:0]      r_pixel_data, w_pixel_data_nxt;
    logic [IDX_W-1:0] r_pixel_index, w_pixel_index_nxt;
    logic             r_frame_done, w_frame_done_nxt;
    logic [PC_W-1:0]  r_pixel_count, w_pixel_count_nxt;
    logic             r_frame_error, w_frame_error_nxt;
    logic             r_overflow, w_overflow_nxt;
    logic             w_error, w_frame_end;

    ws2812_rx_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_din   (i_din),
        .o_din_s (w_din_s),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    // level-duration counter; restarts at 1 on an edge so it reads the exact
    // number of cycles spent at the previous level on the following edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_width <= '0;
        end else if (w_rise || w_fall) begin
            r_width <= CNT_W'(1);
        end else if (r_width != C_RESET) begin
            r_width <= r_width + CNT_W'(1);
        end else begin
            r_width <= r_width;
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt     <= 5'd0;
            r_shift       <= 24'd0;
            r_pix_cnt     <= '0;
            r_ovf_flag    <= 1'b0;
            r_pixel_valid <= 1'b0;
            r_pixel_data  <= 24'd0;
            r_pixel_index <= '0;
            r_frame_done  <= 1'b0;
            r_pixel_count <= '0;
            r_frame_error <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_shift       <= w_shift_nxt;
            r_pix_cnt     <= w_pix_cnt_nxt;
            r_ovf_flag    <= w_ovf_flag_nxt;
            r_pixel_valid <= w_pixel_valid_nxt;
            r_pixel_data  <= w_pixel_data_nxt;
            r_pixel_index <= w_pixel_index_nxt;
            r_frame_done  <= w_frame_done_nxt;
            r_pixel_count <= w_pixel_count_nxt;
            r_frame_error <= w_frame_error_nxt;
            r_overflow    <= w_overflow_nxt;
        end
    end

    // next-state, bit/pixel assembly and frame bookkeeping
    always_comb begin
        w_state_nxt       = r_state;
        w_bit_cnt_nxt     = r_bit_cnt;
        w_shift_nxt       = r_shift;
        w_pix_cnt_nxt     = r_pix_cnt;
        w_ovf_flag_nxt    = r_ovf_flag;
        w_pixel_valid_nxt = 1'b0;
        w_pixel_data_nxt  = r_pixel_data;
        w_pixel_index_nxt = r_pixel_index;
        w_frame_done_nxt  = 1'b0;
        w_pixel_count_nxt = r_pixel_count;
        w_frame_error_nxt = 1'b0;
        w_overflow_nxt    = 1'b0;
        w_error           = 1'b0;
        w_frame_end       = 1'b0;

        // a full pixel is released the cycle after its 24th bit lands
        if (r_bit_cnt == C_PIX_BITS) begin
            w_bit_cnt_nxt = 5'd0;
            if (r_pix_cnt < C_NUM_LED) begin
                w_pixel_valid_nxt = 1'b1;
                w_pixel_data_nxt  = r_shift;
                w_pixel_index_nxt = r_pix_cnt[IDX_W-1:0];
                w_pix_cnt_nxt     = r_pix_cnt + PC_W'(1);
            end else begin
                w_ovf_flag_nxt = 1'b1;
            end
        end else begin
            w_bit_cnt_nxt = r_bit_cnt;
        end

        case (r_state)
            RX_IDLE: begin
                if (!w_din_s && !w_fall && (r_width >= C_RESET)) begin
                    w_state_nxt = RX_ARMED;
                end else begin
                    w_state_nxt = RX_IDLE;
                end
            end
            RX_ARMED: begin
                if (w_rise) begin
                    w_state_nxt = RX_HIGH;
                end else begin
                    w_state_nxt = RX_ARMED;
                end
            end
            RX_HIGH: begin
                if (w_fall) begin
                    if (r_width < C_MIN) begin
                        w_error = 1'b1;
                    end else begin
                        w_shift_nxt   = {r_shift[22:0], (r_width >= C_THRESH)};
                        w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                        w_state_nxt   = RX_LOW;
                    end
                end else if (w_din_s && (r_width > C_MAX)) begin
                    w_error = 1'b1;
                end else begin
                    w_state_nxt = RX_HIGH;
                end
            end
            RX_LOW: begin
                // gap takes priority over a rise arriving in the same cycle
                if (r_width >= C_RESET) begin
                    w_frame_end = 1'b1;
                end else if (w_rise) begin
                    w_state_nxt = RX_HIGH;
                end else begin
                    w_state_nxt = RX_LOW;
                end
            end
            default: begin
                w_state_nxt = RX_IDLE;
            end
        endcase

        if (w_frame_end) begin
            w_frame_done_nxt  = 1'b1;
            w_pixel_count_nxt = r_pix_cnt;
            w_overflow_nxt    = r_ovf_flag;
            w_frame_error_nxt = (r_bit_cnt != 5'd0);
            w_bit_cnt_nxt     = 5'd0;
            w_pix_cnt_nxt     = '0;
            w_ovf_flag_nxt    = 1'b0;
            w_state_nxt       = RX_ARMED;
        end else if (w_error) begin
            w_frame_error_nxt = 1'b1;
            w_bit_cnt_nxt     = 5'd0;
            w_pix_cnt_nxt     = '0;
            w_ovf_flag_nxt    = 1'b0;
            w_state_nxt       = RX_IDLE;
        end else begin
            w_frame_error_nxt = 1'b0;
        end
    end

    assign o_pixel_valid = r_pixel_valid;
    assign o_pixel_data  = r_pixel_data;
    assign o_pixel_index = r_pixel_index;
    assign o_frame_done  = r_frame_done;
    assign o_pixel_count = r_pixel_count;
    assign o_frame_error = r_frame_error;
    assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx: drives WS2812 waveforms and checks decoded
// pixels, frame boundaries, overflow and error handling.
module tb_ws2812_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din = 1'b0;
    logic        o_pixel_valid;
    logic [23:0] o_pixel_data;
    logic [2:0]  o_pixel_index;
    logic        o_frame_done;
    logic [3:0]  o_pixel_count;
    logic        o_frame_error;
    logic        o_overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_fall = 0;

    logic [23:0] pv_data[$];
    int          pv_idx[$];
    int          pv_lat[$];
    int          fd_pcount[$];
    logic        fd_ovf[$];
    logic        fd_err[$];
    int          ferr_cnt = 0;

    logic [23:0] pix_tab [0:8] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF,
                                    24'h000000, 24'hA5A5A5, 24'h5A5A5A, 24'h123456,
                                    24'hDEADBE};

    ws2812_rx dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_din         (din),
        .o_pixel_valid (o_pixel_valid),
        .o_pixel_data  (o_pixel_data),
        .o_pixel_index (o_pixel_index),
        .o_frame_done  (o_frame_done),
        .o_pixel_count (o_pixel_count),
        .o_frame_error (o_frame_error),
        .o_overflow    (o_overflow)
    );

    always #10 clk = ~clk;

    // output monitor, sampled just after each rising edge
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (o_pixel_valid) begin
            pv_data.push_back(o_pixel_data);
            pv_idx.push_back(int'(o_pixel_index));
            pv_lat.push_back(cyc - last_fall);
        end
        if (o_frame_done) begin
            fd_pcount.push_back(int'(o_pixel_count));
            fd_ovf.push_back(o_overflow);
            fd_err.push_back(o_frame_error);
        end
        if (o_frame_error) ferr_cnt = ferr_cnt + 1;
    end

    task automatic hold(input logic v, input int n);
        if (din && !v) last_fall = cyc + 1;
        din = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [23:0] p, input int n, input int h0, input int h1);
        for (int i = 23; i > 23 - n; i--) begin
            if (p[i]) begin
                hold(1'b1, h1);
                hold(1'b0, 62 - h1);
            end else begin
                hold(1'b1, h0);
                hold(1'b0, 62 - h0);
            end
        end
    endtask

    task automatic clear_logs();
        pv_data.delete();
        pv_idx.delete();
        pv_lat.delete();
        fd_pcount.delete();
        fd_ovf.delete();
        fd_err.delete();
        ferr_cnt = 0;
    endtask

    task automatic test_reset();
        logic [34:0] outs;
        rst_n = 1'b0;
        din = 1'b0;
        repeat (3) @(negedge clk);
        outs = {o_pixel_valid, o_pixel_data, o_pixel_index, o_frame_done,
                o_pixel_count, o_frame_error, o_overflow};
        checks++;
        if (outs !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_pixel();
        clear_logs();
        hold(1'b0, 2600);
        send_bits(24'h00FF00, 24, 20, 40);
        hold(1'b0, 2600);
        checks++;
        if (pv_data.size() !== 1) begin
            errors++; $display("FAIL single_pv_count: got %0d expected 1", pv_data.size());
        end else begin
            checks += 3;
            if (pv_data[0] !== 24'h00FF00) begin
                errors++; $display("FAIL single_data: got %h expected 00ff00", pv_data[0]);
            end
            if (pv_idx[0] !== 0) begin
                errors++; $display("FAIL single_index: got %0d expected 0", pv_idx[0]);
            end
            if (pv_lat[0] < 3 || pv_lat[0] > 5) begin
                errors++; $display("FAIL single_latency: got %0d expected 3..5", pv_lat[0]);
            end
        end
        checks++;
        if (fd_pcount.size() !== 1) begin
            errors++; $display("FAIL single_fd_count: got %0d expected 1", fd_pcount.size());
        end else begin
            checks++;
            if (fd_pcount[0] !== 1 || fd_ovf[0] !== 1'b0 || fd_err[0] !== 1'b0) begin
                errors++;
                $display("FAIL single_frame: got count=%0d ovf=%b err=%b expected 1 0 0",
                         fd_pcount[0], fd_ovf[0], fd_err[0]);
            end
        end
        checks += 2;
        if (ferr_cnt !== 0) begin
            errors++; $display("FAIL single_errors: got %0d expected 0", ferr_cnt);
        end
        if (o_pixel_count !== 4'd1) begin
            errors++; $display("FAIL single_count_held: got %0d expected 1", o_pixel_count);
        end
    endtask

    task automatic test_eight_pixels();
        clear_logs();
        for (int i = 0; i < 8; i++) send_bits(pix_tab[i], 24, 20, 40);
        hold(1'b0, 2600);
        checks++;
        if (pv_data.size() !== 8) begin
            errors++; $display("FAIL eight_pv_count: got %0d expected 8", pv_data.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (pv_data[i] !== pix_tab[i] || pv_idx[i] !== i) begin
                    errors++;
                    $display("FAIL eight_pixel%0d: got %h@%0d expected %h@%0d",
                             i, pv_data[i], pv_idx[i], pix_tab[i], i);
                end
            end
        end
        checks++;
        if (fd_pcount.size() !== 1 || fd_pcount[0] !== 8 || fd_ovf[0] !== 1'b0 || ferr_cnt !== 0) begin
            errors++;
            $display("FAIL eight_frame: got frames=%0d count=%0d errs=%0d expected 1 8 0",
                     fd_pcount.size(), fd_pcount.size() > 0 ? fd_pcount[0] : -1, ferr_cnt);
        end
        // decode threshold: 29 cycles reads 0, 30 cycles reads 1
        clear_logs();
        send_bits(24'hC3A55A, 24, 29, 30);
        send_bits(24'h0F0F0F, 24, 29, 30);
        hold(1'b0, 2600);
        checks++;
        if (pv_data.size() !== 2) begin
            errors++; $display("FAIL thresh_pv_count: got %0d expected 2", pv_data.size());
        end else begin
            checks += 2;
            if (pv_data[0] !== 24'hC3A55A) begin
                errors++; $display("FAIL thresh_pixel0: got %h expected c3a55a", pv_data[0]);
            end
            if (pv_data[1] !== 24'h0F0F0F || pv_idx[1] !== 1) begin
                errors++; $display("FAIL thresh_pixel1: got %h@%0d expected 0f0f0f@1", pv_data[1], pv_idx[1]);
            end
        end
    endtask

    task automatic test_overflow();
        clear_logs();
        for (int i = 0; i < 9; i++) send_bits(pix_tab[i], 24, 20, 40);
        hold(1'b0, 2600);
        checks++;
        if (pv_data.size() !== 8) begin
            errors++; $display("FAIL ovf_pv_count: got %0d expected 8", pv_data.size());
        end else begin
            checks++;
            if (pv_data[7] !== pix_tab[7] || pv_idx[7] !== 7) begin
                errors++; $display("FAIL ovf_last_pixel: got %h@%0d expected %h@7", pv_data[7], pv_idx[7], pix_tab[7]);
            end
        end
        checks++;
        if (fd_pcount.size() !== 1 || fd_pcount[0] !== 8 || fd_ovf[0] !== 1'b1 || ferr_cnt !== 0) begin
            errors++;
            $display("FAIL ovf_frame: got frames=%0d count=%0d ovf=%b errs=%0d expected 1 8 1 0",
                     fd_pcount.size(), fd_pcount.size() > 0 ? fd_pcount[0] : -1,
                     fd_ovf.size() > 0 ? fd_ovf[0] : 1'bx, ferr_cnt);
        end
    endtask

    task automatic test_partial();
        clear_logs();
        send_bits(24'hABC000, 12, 20, 40);
        hold(1'b0, 2600);
        checks += 2;
        if (pv_data.size() !== 0) begin
            errors++; $display("FAIL partial_pv_count: got %0d expected 0", pv_data.size());
        end
        if (fd_pcount.size() !== 1 || fd_pcount[0] !== 0 || fd_err[0] !== 1'b1 ||
            fd_ovf[0] !== 1'b0 || ferr_cnt !== 1) begin
            errors++;
            $display("FAIL partial_frame: got frames=%0d errs=%0d expected 1 frame, count 0, err with done",
                     fd_pcount.size(), ferr_cnt);
        end
    endtask

    task automatic test_error(input logic glitch);
        clear_logs();
        send_bits(24'h111111, 24, 20, 40);
        send_bits(24'hFFFFFF, 5, 20, 40);
        if (glitch) hold(1'b1, 3);
        else        hold(1'b1, 80);
        hold(1'b0, 40);
        send_bits(24'hFFFFFF, 8, 20, 40);
        hold(1'b0, 2600);
        send_bits(24'h654321, 24, 20, 40);
        hold(1'b0, 2600);
        checks++;
        if (pv_data.size() !== 2) begin
            errors++; $display("FAIL error%0d_pv_count: got %0d expected 2", glitch, pv_data.size());
        end else begin
            checks++;
            if (pv_data[0] !== 24'h111111 || pv_data[1] !== 24'h654321 || pv_idx[1] !== 0) begin
                errors++;
                $display("FAIL error%0d_pixels: got %h %h@%0d expected 111111 654321@0",
                         glitch, pv_data[0], pv_data[1], pv_idx[1]);
            end
        end
        checks++;
        if (ferr_cnt !== 1 || fd_pcount.size() !== 1 || fd_pcount[0] !== 1 || fd_err[0] !== 1'b0) begin
            errors++;
            $display("FAIL error%0d_frame: got errs=%0d frames=%0d expected 1 1 (count 1, no err with done)",
                     glitch, ferr_cnt, fd_pcount.size());
        end
    endtask

    task automatic test_reset_midframe();
        logic [34:0] outs;
        clear_logs();
        send_bits(24'hFFFFFF, 10, 20, 40);
        hold(1'b1, 10);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        outs = {o_pixel_valid, o_pixel_data, o_pixel_index, o_frame_done,
                o_pixel_count, o_frame_error, o_overflow};
        checks++;
        if (outs !== 35'd0) begin
            errors++; $display("FAIL midreset_outputs: got %h expected 0", outs);
        end
        rst_n = 1'b1;
        hold(1'b1, 50);
        send_bits(24'hFFFFFF, 8, 20, 40);
        hold(1'b0, 2600);
        send_bits(24'h0A0B0C, 24, 20, 40);
        hold(1'b0, 2600);
        checks += 2;
        if (pv_data.size() !== 1 || pv_data[0] !== 24'h0A0B0C || pv_idx[0] !== 0) begin
            errors++;
            $display("FAIL midreset_pixel: got n=%0d data=%h expected 1 0a0b0c",
                     pv_data.size(), pv_data.size() > 0 ? pv_data[0] : 24'hx);
        end
        if (fd_pcount.size() !== 1 || fd_pcount[0] !== 1 || ferr_cnt !== 0) begin
            errors++;
            $display("FAIL midreset_frame: got frames=%0d errs=%0d expected 1 0", fd_pcount.size(), ferr_cnt);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_pixel();
        test_eight_pixels();
        test_overflow();
        test_partial();
        test_error(1'b0);
        test_error(1'b1);
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
